// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl
//   Trigger-driven capture controller for the debug trace buffer. Round-robin
//   arbitrates Tile_num trace sources onto one circular-buffer write port.
//   Runs an arm / trigger / post-trigger sequence, then reads the captured
//   window back oldest entry first.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   tile_din/tile_valid    per-tile trace words (tile i at [i*Fpay +: Fpay])
//   tile_ack               one-hot grant, combinational; word consumed same cycle
//   arm, trig, post_cnt    capture control (post_cnt latched on arm)
//   buf_wr_en/addr, buf_din    registered buffer write port
//   buf_rd_en/addr             registered buffer read port (data 1 cycle later)
//   rd_req, rd_valid, rd_last  readout handshake / qualifiers
//   state                  IDLE=0 ARMED=1 POST=2 DONE=3
//   trace_cnt              number of valid entries (meaningful in DONE)
//
// Build option
//   TRACE_SRCID_EN: the top clog2(Tile_num) bits of buf_din carry the
//   granted tile index instead of tile data.
module trace_capture_ctrl #(
  parameter int Fpay     = 32,
  parameter int Tile_num = 4,
  parameter int TB_AW    = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [Tile_num*Fpay-1:0] tile_din,
  input  logic [Tile_num-1:0]      tile_valid,
  output logic [Tile_num-1:0]      tile_ack,
  input  logic                     arm,
  input  logic                     trig,
  input  logic [TB_AW-1:0]         post_cnt,
  output logic                     buf_wr_en,
  output logic [TB_AW-1:0]         buf_wr_addr,
  output logic [Fpay-1:0]          buf_din,
  output logic                     buf_rd_en,
  output logic [TB_AW-1:0]         buf_rd_addr,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [TB_AW:0]           trace_cnt
);

  localparam int SW = $clog2(Tile_num);
  localparam logic [TB_AW:0]   DEPTH = {1'b1, {TB_AW{1'b0}}};
  localparam logic [TB_AW-1:0] AMAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} st_e;

  st_e              st;
  logic [SW-1:0]    rr_ptr;
  logic [TB_AW-1:0] wr_ptr, rd_ptr, post_lat, post_rem;
  logic             wrapped;
  logic [TB_AW:0]   rd_cnt;
  logic             last_iss;

  assign state = st;

  // Round-robin: scan from rr_ptr upward; iterate downward so the
  // lowest offset from rr_ptr is the last (winning) assignment.
  logic [SW-1:0]   gnt_idx, k;
  logic            gnt_any, capturing, grant;
  logic [Fpay-1:0] gnt_word;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = '0;
    for (int i = Tile_num-1; i >= 0; i--) begin
      k = SW'((int'(rr_ptr) + i) % Tile_num);
      if (tile_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
      end
    end
  end

  assign capturing = (st == ARMED) || (st == POST);
  assign grant     = capturing && gnt_any;
  assign tile_ack  = grant ? (Tile_num'(1) << gnt_idx) : '0;

  always_comb begin
    gnt_word = tile_din[int'(gnt_idx)*Fpay +: Fpay];
`ifdef TRACE_SRCID_EN
    gnt_word[Fpay-1 -: SW] = gnt_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wrapped     <= 1'b0;
      post_lat    <= '0;
      post_rem    <= '0;
      rd_cnt      <= '0;
      last_iss    <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_din     <= '0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      trace_cnt   <= '0;
    end else begin
      buf_wr_en <= 1'b0;
      buf_rd_en <= 1'b0;
      last_iss  <= 1'b0;
      // read data returns one cycle after the read strobe
      rd_valid  <= buf_rd_en;
      rd_last   <= last_iss;

      if (grant) begin
        buf_wr_en   <= 1'b1;
        buf_wr_addr <= wr_ptr;
        buf_din     <= gnt_word;
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (int'(gnt_idx) == Tile_num-1) ? '0 : gnt_idx + 1'b1;
        if (wr_ptr == AMAX) wrapped <= 1'b1;
        // once wrapped, the oldest entry is the one after the newest write
        if (wrapped || wr_ptr == AMAX) rd_ptr <= wr_ptr + 1'b1;
        // saturating entry count equals wrapped ? DEPTH : wr_ptr
        if (trace_cnt != DEPTH) trace_cnt <= trace_cnt + 1'b1;
      end

      if ((st == IDLE || st == DONE) && arm) begin
        st        <= ARMED;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        wrapped   <= 1'b0;
        rd_cnt    <= '0;
        trace_cnt <= '0;
        post_lat  <= post_cnt;
      end else begin
        case (st)
          ARMED: if (trig) begin
            if (post_lat == '0) st <= DONE;
            else begin
              st       <= POST;
              post_rem <= post_lat;
            end
          end
          POST: if (grant) begin
            post_rem <= post_rem - 1'b1;
            if (post_rem == TB_AW'(1)) st <= DONE;
          end
          DONE: if (rd_req && rd_cnt != trace_cnt) begin
            buf_rd_en   <= 1'b1;
            buf_rd_addr <= rd_ptr;
            rd_ptr      <= rd_ptr + 1'b1;
            rd_cnt      <= rd_cnt + 1'b1;
            if (rd_cnt + 1'b1 == trace_cnt) begin
              last_iss <= 1'b1;
              st       <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
module tb_trace_capture_ctrl;
  localparam int FP = 32, TN = 4, AW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [TN*FP-1:0] tile_din;
  logic [TN-1:0]  tile_valid, tile_ack;
  logic           arm, trig, rd_req;
  logic [AW-1:0]  post_cnt;
  logic           buf_wr_en, buf_rd_en, rd_valid, rd_last;
  logic [AW-1:0]  buf_wr_addr, buf_rd_addr;
  logic [FP-1:0]  buf_din;
  logic [1:0]     state;
  logic [AW:0]    trace_cnt;

  always #5 clk = ~clk;

  trace_capture_ctrl #(.Fpay(FP), .Tile_num(TN), .TB_AW(AW)) dut (
    .clk(clk), .reset(reset), .tile_din(tile_din), .tile_valid(tile_valid),
    .tile_ack(tile_ack), .arm(arm), .trig(trig), .post_cnt(post_cnt),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_din(buf_din),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_last(rd_last), .state(state), .trace_cnt(trace_cnt)
  );

  int total = 0, bad = 0;

  typedef struct {
    logic arm; logic [3:0] vld; logic trig; logic rdq;
    logic [1:0] st; logic [3:0] ack;
    logic wr; logic [3:0] waddr; logic [1:0] src;
    logic rd; logic [3:0] raddr; logic rv; logic rl;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic a, input logic [3:0] v, input logic t, input logic q,
                     input logic [1:0] s, input logic [3:0] k,
                     input logic w, input logic [3:0] wa, input logic [1:0] sr,
                     input logic r, input logic [3:0] ra, input logic rv, input logic rl);
    vec_t e;
    e.arm = a; e.vld = v; e.trig = t; e.rdq = q; e.st = s; e.ack = k;
    e.wr = w; e.waddr = wa; e.src = sr; e.rd = r; e.raddr = ra; e.rv = rv; e.rl = rl;
    tbl.push_back(e);
  endtask

  function automatic logic [31:0] tdata(input int i);
    return 32'h0000_00A0 + 32'(i);
  endfunction

  function automatic logic [31:0] exp_din(input int idx, input logic [31:0] d);
    logic [31:0] r;
    r = d;
`ifdef TRACE_SRCID_EN
    r[31:30] = idx[1:0];
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_tdata();
    for (int i = 0; i < TN; i++) tile_din[i*FP +: FP] = tdata(i);
  endtask

  // 5 pre-trigger grants + 3 post-trigger grants with all tiles valid
  task automatic capture8();
    arm = 1; post_cnt = 3; tile_valid = 4'hF; step();
    arm = 0;
    for (int i = 0; i < 5; i++) begin trig = (i == 4); step(); end
    trig = 0;
    repeat (3) step();
    tile_valid = 0;
    chk("cap8 state", state, 3);
    chk("cap8 cnt", trace_cnt, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nval, lastpos;
    logic [AW-1:0] first, lasta;

    // basic capture table (post_cnt=3), applied right after reset
    add(1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 1, 4'h1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 1, 4'h2, 1, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 1, 4'h4, 1, 1, 1, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 1, 4'h8, 1, 2, 2, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 1, 4'h1, 1, 3, 3, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 2, 4'h2, 1, 4, 0, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 2, 4'h4, 1, 5, 1, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 2, 4'h8, 1, 6, 2, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, 3, 4'h0, 1, 7, 3, 0, 0, 0, 0);
    add(0, 4'h0, 0, 1, 3, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 11; c <= 17; c++)
      add(0, 4'h0, 0, 1, 3, 4'h0, 0, 0, 0, 1, 4'(c-11), (c >= 12), 0);
    add(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 7, 1, 0);
    add(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);

    reset = 1; arm = 0; trig = 0; rd_req = 0; tile_valid = 0; post_cnt = 3;
    set_tdata();
    step(); step();
    chk("rst state", state, 0);
    chk("rst ack", tile_ack, 0);
    chk("rst wr_en", buf_wr_en, 0);
    chk("rst rd_en", buf_rd_en, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_last", rd_last, 0);
    chk("rst wr_addr", buf_wr_addr, 0);
    chk("rst rd_addr", buf_rd_addr, 0);
    chk("rst din", buf_din, 0);
    chk("rst cnt", trace_cnt, 0);
    reset = 0;

    foreach (tbl[i]) begin
      arm = tbl[i].arm; tile_valid = tbl[i].vld; trig = tbl[i].trig; rd_req = tbl[i].rdq;
      #1;
      chk($sformatf("row%0d state", i), state, tbl[i].st);
      chk($sformatf("row%0d ack", i), tile_ack, tbl[i].ack);
      chk($sformatf("row%0d wr_en", i), buf_wr_en, tbl[i].wr);
      if (tbl[i].wr) begin
        chk($sformatf("row%0d wr_addr", i), buf_wr_addr, tbl[i].waddr);
        chk($sformatf("row%0d din", i), buf_din, exp_din(tbl[i].src, tdata(tbl[i].src)));
      end
      chk($sformatf("row%0d rd_en", i), buf_rd_en, tbl[i].rd);
      if (tbl[i].rd) chk($sformatf("row%0d rd_addr", i), buf_rd_addr, tbl[i].raddr);
      chk($sformatf("row%0d rd_valid", i), rd_valid, tbl[i].rv);
      chk($sformatf("row%0d rd_last", i), rd_last, tbl[i].rl);
      if (tbl[i].st == 3) chk($sformatf("row%0d cnt", i), trace_cnt, 8);
      step();
    end
    arm = 0; trig = 0; rd_req = 0; tile_valid = 0;

    // wrap: 20 pre-trigger writes from tile 1, then 2 post-trigger
    arm = 1; post_cnt = 2; step();
    arm = 0; tile_valid = 4'b0010;
    for (int i = 0; i < 20; i++) begin trig = (i == 19); step(); end
    trig = 0;
    chk("wrap post state", state, 2);
    step(); step();
    chk("wrap done state", state, 3);
    chk("wrap cnt", trace_cnt, 16);
    chk("wrap ack in done", tile_ack, 0);
    tile_valid = 0; rd_req = 1;
    n = 0; nval = 0; lastpos = 0; first = '0; lasta = '0;
    for (int c = 0; c < 20; c++) begin
      if (c == 16) rd_req = 0;
      step();
      if (buf_rd_en) begin
        if (n == 0) first = buf_rd_addr;
        lasta = buf_rd_addr;
        n++;
      end
      if (rd_valid) begin
        nval++;
        if (rd_last) lastpos = nval;
      end
    end
    chk("wrap rd count", n, 16);
    chk("wrap first addr", first, 6);
    chk("wrap last addr", lasta, 5);
    chk("wrap rd_last pos", lastpos, 16);
    chk("wrap end state", state, 0);

    // post_cnt=0: trigger-cycle grant is written, then DONE
    arm = 1; post_cnt = 0; step();
    arm = 0; tile_valid = 4'b0100; trig = 1; #1;
    chk("p0 ack", tile_ack, 4'b0100);
    step(); trig = 0;
    chk("p0 state", state, 3);
    chk("p0 wr_en", buf_wr_en, 1);
    chk("p0 wr_addr", buf_wr_addr, 0);
    chk("p0 din", buf_din, exp_din(2, tdata(2)));
    chk("p0 no grant", tile_ack, 0);
    step();
    chk("p0 no write", buf_wr_en, 0);
    chk("p0 cnt", trace_cnt, 1);

    // arm in DONE, arm in POST ignored, trig in IDLE ignored
    arm = 1; post_cnt = 3; tile_valid = 4'b0001; step();
    arm = 0;
    chk("ign rearm state", state, 1);
    step();
    chk("ign rearm wr_addr", buf_wr_addr, 0);
    chk("ign rearm wr_en", buf_wr_en, 1);
    trig = 1; step(); trig = 0;
    chk("ign post state", state, 2);
    chk("ign trig wr_addr", buf_wr_addr, 1);
    arm = 1; step(); arm = 0;
    chk("ign arm-in-post state", state, 2);
    chk("ign arm-in-post wr_addr", buf_wr_addr, 2);
    step(); step();
    chk("ign done state", state, 3);
    chk("ign cnt", trace_cnt, 5);
    chk("ign last wr_addr", buf_wr_addr, 4);
    tile_valid = 0; rd_req = 1; step();
    chk("ign rd first", buf_rd_addr, 0);
    chk("ign rd_en", buf_rd_en, 1);
    repeat (4) step();
    rd_req = 0;
    chk("ign rd end state", state, 0);
    chk("ign rd last addr", buf_rd_addr, 4);
    trig = 1; step(); trig = 0;
    chk("ign trig idle", state, 0);

    // empty capture: rd_req ignored, stays DONE
    arm = 1; post_cnt = 0; step();
    arm = 0; trig = 1; step(); trig = 0;
    chk("empty state", state, 3);
    chk("empty cnt", trace_cnt, 0);
    rd_req = 1; step(); step(); rd_req = 0;
    chk("empty rd_en", buf_rd_en, 0);
    chk("empty stays done", state, 3);

    // source-id field
    tile_din[1*FP +: FP] = 32'hFFFF_FFFF;
    tile_din[3*FP +: FP] = 32'hFFFF_FFFF;
    arm = 1; post_cnt = 1; tile_valid = 4'b1000; step();
    arm = 0; step();
    chk("srcid tile3", buf_din, exp_din(3, 32'hFFFF_FFFF));
    tile_valid = 4'b0010; trig = 1; step(); trig = 0;
    chk("srcid tile1", buf_din, exp_din(1, 32'hFFFF_FFFF));
    chk("srcid state", state, 2);
    step();
    chk("srcid done", state, 3);
    tile_valid = 0;
    set_tdata();

    // reset during readout after 3 of 8 words
    capture8();
    rd_req = 1; repeat (3) step(); rd_req = 0;
    chk("mr 3rd addr", buf_rd_addr, 2);
    reset = 1; tile_valid = 4'hF; step();
    chk("mr state", state, 0);
    chk("mr ack", tile_ack, 0);
    chk("mr wr_en", buf_wr_en, 0);
    chk("mr rd_en", buf_rd_en, 0);
    chk("mr rd_valid", rd_valid, 0);
    chk("mr rd_last", rd_last, 0);
    chk("mr wr_addr", buf_wr_addr, 0);
    chk("mr rd_addr", buf_rd_addr, 0);
    chk("mr din", buf_din, 0);
    chk("mr cnt", trace_cnt, 0);
    reset = 0; arm = 1; post_cnt = 1; step();
    arm = 0;
    chk("mr rr tile0", tile_ack, 4'b0001);
    step();
    chk("mr new wr_en", buf_wr_en, 1);
    chk("mr new wr_addr", buf_wr_addr, 0);
    tile_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
